// File: rtl/leds_ctrl.sv
// Button front end for the screen-leds display: synchronise, debounce and
// auto-repeat two push-buttons, then commit row/byte values once per frame.
module leds_ctrl #(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int REPEAT_DELAY    = 6000000,
  parameter int REPEAT_PERIOD   = 2100000,
  parameter int NUM_ROWS        = 6,
  parameter int ROW_INIT        = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc_row,
  input  logic       inc_byte,
  input  logic       frame_tick,
  output logic [3:0] row_led,
  output logic [7:0] byte_led,
  output logic [7:0] disp,
  output logic       row_evt,
  output logic       byte_evt,
  output logic       pending
);

  localparam int MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_P = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
  localparam int CW    = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] DB_LIM  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] RD_LIM  = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] RP_LIM  = CW'(REPEAT_PERIOD);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    HOLD,
    REPEAT,
    RELEASE_DB
  } btn_state_t;

  logic [1:0] raw;
  logic [1:0] evt_int;

  assign raw = {inc_byte, inc_row};

  // Index 0 handles the row button, index 1 the byte button.
  for (genvar b = 0; b < 2; b++) begin : g_btn
    btn_state_t    state;
    btn_state_t    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          meta;
    logic          s;
    logic          fire;

    always_ff @(posedge clk) begin
      if (rst) begin
        meta  <= 1'b0;
        s     <= 1'b0;
        state <= IDLE;
        cnt   <= '0;
      end else begin
        meta  <= raw[b];
        s     <= meta;
        state <= state_nxt;
        cnt   <= cnt_nxt;
      end
    end

    // A level change on s always takes priority over a counter match.
    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      fire      = 1'b0;
      case (state)
        IDLE: begin
          if (s) begin
            state_nxt = PRESS_DB;
            cnt_nxt   = CNT_ONE;
          end
        end
        PRESS_DB: begin
          if (!s) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (cnt == DB_LIM) begin
            fire      = 1'b1;
            state_nxt = HOLD;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        HOLD: begin
          if (!s) begin
            state_nxt = RELEASE_DB;
            cnt_nxt   = CNT_ONE;
          end else if (cnt == RD_LIM) begin
            fire      = 1'b1;
            state_nxt = REPEAT;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        REPEAT: begin
          if (!s) begin
            state_nxt = RELEASE_DB;
            cnt_nxt   = CNT_ONE;
          end else if (cnt == RP_LIM) begin
            fire    = 1'b1;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        RELEASE_DB: begin
          if (s) begin
            state_nxt = HOLD;
            cnt_nxt   = '0;
          end else if (cnt == DB_LIM) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end

    assign evt_int[b] = fire;
  end

  logic [3:0] row_sh;
  logic [3:0] row_sh_nxt;
  logic [7:0] byte_sh;
  logic [7:0] byte_sh_nxt;
  logic [3:0] row_led_nxt;
  logic [7:0] byte_led_nxt;

  // The commit takes the post-event shadow so a coincident event is not lost.
  always_comb begin
    row_sh_nxt = row_sh;
    if (evt_int[0]) begin
      row_sh_nxt = (row_sh == 4'(NUM_ROWS - 1)) ? 4'd0 : row_sh + 4'd1;
    end
    byte_sh_nxt  = byte_sh + {7'd0, evt_int[1]};
    row_led_nxt  = frame_tick ? row_sh_nxt : row_led;
    byte_led_nxt = frame_tick ? byte_sh_nxt : byte_led;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_sh   <= 4'(ROW_INIT);
      byte_sh  <= 8'd0;
      row_led  <= 4'(ROW_INIT);
      byte_led <= 8'd0;
      row_evt  <= 1'b0;
      byte_evt <= 1'b0;
      pending  <= 1'b0;
    end else begin
      row_sh   <= row_sh_nxt;
      byte_sh  <= byte_sh_nxt;
      row_led  <= row_led_nxt;
      byte_led <= byte_led_nxt;
      row_evt  <= evt_int[0];
      byte_evt <= evt_int[1];
      pending  <= (row_sh_nxt != row_led_nxt) || (byte_sh_nxt != byte_led_nxt);
    end
  end

  assign disp = byte_led;

endmodule

// File: tb/tb_leds_ctrl.sv
// Self-checking bench for leds_ctrl: scenario tasks plus a random run, all
// compared against a run-length based reference model.
module tb_leds_ctrl;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;
  localparam int NR = 6;
  localparam int RI = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inc_row = 1'b0;
  logic       inc_byte = 1'b0;
  logic       frame_tick = 1'b0;
  logic [3:0] row_led;
  logic [7:0] byte_led;
  logic [7:0] disp;
  logic       row_evt;
  logic       byte_evt;
  logic       pending;

  leds_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP),
    .NUM_ROWS(NR),
    .ROW_INIT(RI)
  ) dut (
    .clk(clk),
    .rst(rst),
    .inc_row(inc_row),
    .inc_byte(inc_byte),
    .frame_tick(frame_tick),
    .row_led(row_led),
    .byte_led(byte_led),
    .disp(disp),
    .row_evt(row_evt),
    .byte_evt(byte_evt),
    .pending(pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  // Reference model: button behaviour expressed as run lengths of the
  // synchronised level and the absolute cycle of the next due repeat.
  int m_row_sh = RI, m_row_led = RI, m_byte_sh = 0, m_byte_led = 0;
  bit m_row_evt = 0, m_byte_evt = 0, m_pending = 0;
  bit h1[2], h2[2], acc[2];
  int hr[2], lr[2], nxt[2];

  logic [22:0] dut_vec;
  assign dut_vec = {row_led, byte_led, disp, row_evt, byte_evt, pending};

  localparam logic [22:0] RESET_VEC = {4'd2, 8'd0, 8'd0, 3'b000};

  function automatic logic [22:0] exp_vec();
    logic [3:0] r;
    logic [7:0] y;
    r = m_row_led[3:0];
    y = m_byte_led[7:0];
    return {r, y, y, m_row_evt, m_byte_evt, m_pending};
  endfunction

  task automatic model_step();
    bit s;
    bit ev[2];
    cyc++;
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        h1[b] = 0; h2[b] = 0; acc[b] = 0; hr[b] = 0; lr[b] = 0; nxt[b] = 0;
      end
      m_row_sh = RI; m_row_led = RI; m_byte_sh = 0; m_byte_led = 0;
      m_row_evt = 0; m_byte_evt = 0; m_pending = 0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        s = h2[b];
        h2[b] = h1[b];
        h1[b] = (b == 0) ? inc_row : inc_byte;
        ev[b] = 0;
        if (!acc[b]) begin
          if (s) begin
            hr[b]++;
            if (hr[b] == D + 1) begin
              ev[b] = 1; acc[b] = 1; lr[b] = 0; nxt[b] = cyc + RD + 1;
            end
          end else begin
            hr[b] = 0;
          end
        end else if (!s) begin
          lr[b]++;
          if (lr[b] == D + 1) begin
            acc[b] = 0; hr[b] = 0; lr[b] = 0;
          end
        end else if (lr[b] > 0) begin
          lr[b] = 0; nxt[b] = cyc + RD + 1;
        end else if (cyc == nxt[b]) begin
          ev[b] = 1; nxt[b] = cyc + RP + 1;
        end
      end
      if (ev[0]) m_row_sh = (m_row_sh + 1) % NR;
      if (ev[1]) m_byte_sh = (m_byte_sh + 1) % 256;
      if (frame_tick) begin
        m_row_led = m_row_sh;
        m_byte_led = m_byte_sh;
      end
      m_pending = (m_row_sh != m_row_led) || (m_byte_sh != m_byte_led);
      m_row_evt = ev[0];
      m_byte_evt = ev[1];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; inc_row = 0; inc_byte = 0; frame_tick = 0;
    repeat (2) tick();
    rst = 0;
    checks++;
    if (dut_vec !== RESET_VEC) $display("[TB] FAIL reset_values got=%h exp=%h", dut_vec, RESET_VEC);
    else passed++;
    for (int i = 0; i < 10; i++) begin
      frame_tick = ($urandom_range(0, 1) == 1);
      tick();
      checks++;
      if (dut_vec !== RESET_VEC) $display("[TB] FAIL reset_frame cyc=%0d got=%h exp=%h", cyc, dut_vec, RESET_VEC);
      else passed++;
    end
    frame_tick = 0;
  endtask

  task automatic test_single_press();
    int k;
    int cnt = 0;
    int at = -1;
    repeat ($urandom_range(2, 6)) tick();
    inc_byte = 1;
    k = cyc + 1;
    for (int i = 0; i < 30; i++) begin
      if (i == 10) inc_byte = 0;
      tick();
      if (byte_evt) begin cnt++; at = cyc; end
      checks++;
      if (dut_vec !== exp_vec()) $display("[TB] FAIL single_press cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
      else passed++;
    end
    checks++;
    if (cnt != 1 || at != k + 6) $display("[TB] FAIL single_evt count=%0d at=+%0d exp count=1 at=+6", cnt, at - k);
    else passed++;
    checks++;
    if (byte_led !== 8'd0 || pending !== 1'b1) $display("[TB] FAIL single_precommit byte_led=%0d pending=%b exp 0/1", byte_led, pending);
    else passed++;
    frame_tick = 1;
    tick();
    frame_tick = 0;
    checks++;
    if (byte_led !== 8'd1 || disp !== 8'd1 || pending !== 1'b0) $display("[TB] FAIL single_commit byte_led=%0d disp=%0d pending=%b exp 1/1/0", byte_led, disp, pending);
    else passed++;
  endtask

  task automatic test_bounce();
    int cnt = 0;
    for (int i = 0; i < 55; i++) begin
      inc_row = (i < 40) && ((i / 2) % 2 == 0);
      tick();
      if (row_evt) cnt++;
      checks++;
      if (dut_vec !== exp_vec()) $display("[TB] FAIL bounce cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
      else passed++;
    end
    frame_tick = 1;
    tick();
    frame_tick = 0;
    checks++;
    if (cnt != 0 || row_led !== 4'd2) $display("[TB] FAIL bounce_result evts=%0d row_led=%0d exp 0/2", cnt, row_led);
    else passed++;
  endtask

  task automatic test_hold_repeat();
    int k;
    int got[$];
    int exp_off[7] = '{6, 27, 36, 45, 54, 63, 72};
    inc_row = 1;
    k = cyc + 1;
    for (int i = 0; i < 100; i++) begin
      if (i == 79) inc_row = 0;
      tick();
      if (row_evt) got.push_back(cyc - k);
      checks++;
      if (dut_vec !== exp_vec()) $display("[TB] FAIL hold_repeat cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
      else passed++;
    end
    checks++;
    if (got.size() != 7) $display("[TB] FAIL repeat_count got=%0d exp=7", got.size());
    else passed++;
    for (int i = 0; i < 7 && i < got.size(); i++) begin
      checks++;
      if (got[i] != exp_off[i]) $display("[TB] FAIL repeat_time idx=%0d got=+%0d exp=+%0d", i, got[i], exp_off[i]);
      else passed++;
    end
    frame_tick = 1;
    tick();
    frame_tick = 0;
    checks++;
    if (row_led !== 4'd3 || pending !== 1'b0) $display("[TB] FAIL row_wrap row_led=%0d pending=%b exp 3/0", row_led, pending);
    else passed++;
  endtask

  task automatic test_simultaneous_wrap();
    int k;
    int prev_row;
    int row_at = -1;
    int byte_at = -1;
    inc_byte = 1;
    for (int i = 0; i < 4000 && m_byte_sh != 255; i++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) $display("[TB] FAIL preload cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
      else passed++;
    end
    inc_byte = 0;
    repeat (15) tick();
    frame_tick = 1;
    tick();
    frame_tick = 0;
    checks++;
    if (byte_led !== 8'd255) $display("[TB] FAIL preload_commit byte_led=%0d exp=255", byte_led);
    else passed++;
    prev_row = m_row_sh;
    inc_row = 1;
    inc_byte = 1;
    k = cyc + 1;
    for (int i = 0; i < 25; i++) begin
      if (i == 10) begin inc_row = 0; inc_byte = 0; end
      tick();
      if (row_evt && row_at < 0) row_at = cyc;
      if (byte_evt && byte_at < 0) byte_at = cyc;
      checks++;
      if (dut_vec !== exp_vec()) $display("[TB] FAIL simultaneous cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
      else passed++;
    end
    checks++;
    if (row_at != k + 6 || byte_at != k + 6) $display("[TB] FAIL simul_timing row=+%0d byte=+%0d exp +6/+6", row_at - k, byte_at - k);
    else passed++;
    frame_tick = 1;
    tick();
    frame_tick = 0;
    checks++;
    if (byte_led !== 8'd0 || row_led !== 4'((prev_row + 1) % NR)) $display("[TB] FAIL byte_wrap byte_led=%0d row_led=%0d exp 0/%0d", byte_led, row_led, (prev_row + 1) % NR);
    else passed++;
  endtask

  task automatic test_commit_coincident_reset();
    int k;
    int r;
    int at = -1;
    int prev_byte;
    prev_byte = m_byte_sh;
    inc_byte = 1;
    k = cyc + 1;
    for (int i = 0; i < 6; i++) tick();
    frame_tick = 1;
    tick();
    frame_tick = 0;
    checks++;
    if (byte_evt !== 1'b1 || byte_led !== 8'((prev_byte + 1) % 256) || pending !== 1'b0)
      $display("[TB] FAIL coincident cyc=+%0d evt=%b byte_led=%0d pending=%b exp 1/%0d/0", cyc - k, byte_evt, byte_led, pending, (prev_byte + 1) % 256);
    else passed++;
    repeat (5) tick();
    rst = 1;
    repeat (2) tick();
    checks++;
    if (dut_vec !== RESET_VEC) $display("[TB] FAIL midhold_reset got=%h exp=%h", dut_vec, RESET_VEC);
    else passed++;
    rst = 0;
    r = cyc;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (byte_evt && at < 0) at = cyc;
      checks++;
      if (dut_vec !== exp_vec()) $display("[TB] FAIL after_reset cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
      else passed++;
    end
    checks++;
    if (at != r + 7) $display("[TB] FAIL fresh_evt at=+%0d exp=+7 from last reset edge", at - r);
    else passed++;
    inc_byte = 0;
    repeat (12) tick();
  endtask

  task automatic test_random();
    int run_r = 0;
    int run_b = 0;
    for (int i = 0; i < 800; i++) begin
      if (run_r == 0) begin inc_row = ~inc_row; run_r = $urandom_range(1, 30); end
      if (run_b == 0) begin inc_byte = ~inc_byte; run_b = $urandom_range(1, 30); end
      run_r--;
      run_b--;
      frame_tick = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 299) == 0);
      tick();
      checks++;
      if (dut_vec !== exp_vec()) $display("[TB] FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
      else passed++;
    end
    inc_row = 0; inc_byte = 0; frame_tick = 0; rst = 0;
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_hold_repeat();
    test_simultaneous_wrap();
    test_commit_coincident_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog cyc=%0d checks=%0d", cyc, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
